// File: rtl/quadrature_step_generator.sv
// quadrature_step_generator: turns "move N detents in direction D" into a held Gray-code a/b waveform
module quadrature_step_generator #(
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_dir,
  input  logic [CNT_WIDTH-1:0] cmd_count,
  input  logic                 abort,
  output logic                 quad_a,
  output logic                 quad_b,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] steps_remaining
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [1:0] phase, phase_n;
  logic [7:0] hold, hold_n;
  logic abort_lat, abort_n, dir, dir_n, done_n, accept, stop;
  logic [CNT_WIDTH-1:0] steps_n;
  logic [1:0] ab_n;
  function automatic logic [1:0] gray(input logic d, input logic [1:0] p);
    logic [1:0] v;
    v = (p == 2'd0) ? 2'b10 : (p == 2'd1) ? 2'b11 : (p == 2'd2) ? 2'b01 : 2'b00;
    return d ? v : {v[0], v[1]};
  endfunction
  assign accept = cmd_valid & cmd_ready;
  assign stop = (steps_remaining == CNT_WIDTH'(1)) | abort_lat | abort;
  assign ab_n = (state_n == RUN) ? gray(dir_n, phase_n) : 2'b00;
  // next-state: accept in IDLE, walk four held phases per detent in RUN
  always_comb begin
    state_n = state;
    phase_n = phase;
    hold_n = hold;
    abort_n = abort_lat;
    dir_n = dir;
    steps_n = steps_remaining;
    done_n = 1'b0;
    if (state == IDLE) begin
      abort_n = 1'b0;
      if (accept) begin
        dir_n = cmd_dir;
        steps_n = cmd_count;
        done_n = (cmd_count == '0);
        state_n = (cmd_count == '0) ? IDLE : RUN;
        phase_n = 2'd0;
        hold_n = 8'd0;
      end
    end else begin
      abort_n = abort_lat | abort;
      hold_n = hold + 8'd1;
      if (hold == 8'(HOLD_CYCLES - 1)) begin
        hold_n = 8'd0;
        phase_n = phase + 2'd1;
        if (phase == 2'd3) begin
          steps_n = steps_remaining - CNT_WIDTH'(1);
          if (stop) begin
            state_n = IDLE;
            done_n = 1'b1;
            abort_n = 1'b0;
            phase_n = 2'd0;
          end
        end
      end
    end
  end
  // register state and all outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      phase <= 2'd0;
      hold <= 8'd0;
      abort_lat <= 1'b0;
      dir <= 1'b0;
      steps_remaining <= '0;
      done <= 1'b0;
      busy <= 1'b0;
      cmd_ready <= 1'b1;
      quad_a <= 1'b0;
      quad_b <= 1'b0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      hold <= hold_n;
      abort_lat <= abort_n;
      dir <= dir_n;
      steps_remaining <= steps_n;
      done <= done_n;
      busy <= (state_n == RUN);
      cmd_ready <= (state_n != RUN);
      quad_a <= ab_n[1];
      quad_b <= ab_n[0];
    end
  end
endmodule

// File: tb/tb_quadrature_step_generator.sv
// tb_quadrature_step_generator: random commands checked cycle by cycle against a timeline model
module tb_quadrature_step_generator;
  localparam int H = 4;
  localparam int W = 8;
  logic clk = 0, rst = 1, cmd_valid = 0, cmd_dir = 0, abort = 0;
  logic [W-1:0] cmd_count = '0;
  logic cmd_ready, quad_a, quad_b, busy, done;
  logic [W-1:0] steps_remaining;
  int tests = 0, fails = 0, last_steps = 0;
  logic [1:0] cw [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

  quadrature_step_generator #(.HOLD_CYCLES(H), .CNT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_count(cmd_count), .abort(abort),
    .quad_a(quad_a), .quad_b(quad_b), .busy(busy), .done(done),
    .steps_remaining(steps_remaining)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] ab, input logic bz, input logic dn, input int st);
    check({tag, "_ab"}, 32'({quad_a, quad_b}), 32'(ab));
    check({tag, "_busy"}, 32'(busy), 32'(bz));
    check({tag, "_done"}, 32'(done), 32'(dn));
    check({tag, "_ready"}, 32'(cmd_ready), 32'(!bz));
    check({tag, "_steps"}, 32'(steps_remaining), 32'(st));
  endtask

  function automatic logic [1:0] ab_of(input logic d, input int p);
    logic [1:0] v;
    v = cw[p];
    return d ? v : {v[0], v[1]};
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cmd_valid = 0;
      abort = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      expect_out("idle", 2'b00, 0, 0, last_steps);
    end
    abort = 0;
  endtask

  // ka: state index during which abort is high (-1 none); ra: index after which reset hits (-1 none)
  task automatic run_cmd(input logic d, input int n, input int ka, input int ra);
    int det, per;
    per = 4 * H;
    cmd_valid = 1;
    cmd_dir = d;
    cmd_count = W'(n);
    abort = 0;
    @(posedge clk);
    #1;
    cmd_valid = 0;
    cmd_dir = 1'($urandom);
    cmd_count = W'($urandom);
    if (n == 0) begin
      @(negedge clk);
      expect_out("zero", 2'b00, 0, 1, 0);
      last_steps = 0;
      return;
    end
    det = (ka < 0) ? n : (((ka + per) / per) < n ? ((ka + per) / per) : n);
    for (int k = 0; k <= per * det; k++) begin
      @(negedge clk);
      if (k < per * det)
        expect_out("run", ab_of(d, (k % per) / H), 1, 0, n - k / per);
      else
        expect_out("end", 2'b00, 0, 1, n - det);
      if (k == ra) begin
        rst = 1;
        cmd_valid = 0;
        abort = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        expect_out("rst", 2'b00, 0, 0, 0);
        last_steps = 0;
        return;
      end
      abort = (k == ka);
      cmd_valid = (k < per * det) ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd_count = W'($urandom);
    end
    abort = 0;
    last_steps = n - det;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_out("reset", 2'b00, 0, 0, 0);
    rst = 0;
    idle_cycles(2);
    run_cmd(1, 1, -1, -1);
    run_cmd(0, 3, -1, -1);
    idle_cycles(1);
    run_cmd(1, 5, 6, -1);
    run_cmd(0, 0, -1, -1);
    run_cmd(1, 2, -1, 4 * H + H + 1);
    run_cmd(1, 2, -1, -1);
    run_cmd(0, 2, 8 * H - 1, -1);
    run_cmd(1, 3, 4 * H - 1, -1);
    run_cmd(0, 255, -1, -1);
    for (int i = 0; i < 40; i++) begin
      int n, ka;
      n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      ka = (n > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, 4 * H * n - 1) : -1;
      run_cmd(1'($urandom), n, ka, -1);
      idle_cycles($urandom_range(0, 2));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
